reg_write_arbiter: RTL and testbench

Round-robin arbiter that shares one 8-bit enabled storage register among several requesters. It accepts write requests over a req/ack handshake and commits one winner per write slot by driving the register's enable and data inputs. It reports which requester was served. It sits directly in front of the register instance, whose enable/data ports are driven only by this block.

---
 rtl/reg_arb_pkg.sv | 19 +
 rtl/rr_grant_picker.sv | 38 +++
 rtl/reg_write_arbiter.sv | 98 +++++++++
 tb/tb_reg_write_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register write arbiter.
// Included by the picker and the top-level arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int N_REQ_DEF  = 4;

  // A zero gap still needs a one-bit counter so the port widths stay legal.
  function automatic int gap_cnt_width(input int min_gap);
    return (min_gap < 1) ? 1 : $clog2(min_gap + 1);
  endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// Combinational round-robin search: the first requester after last_grant wins.
// Priority wraps modulo N_REQ, so the previous winner is always examined last.
module rr_grant_picker
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic                     any_valid,
  output logic [$clog2(N_REQ)-1:0] winner
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0] cand [N_REQ];

  // cand[0] is the requester with the highest priority this cycle.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand[gi] = IDW'((int'(last_grant) + 1 + gi) % N_REQ);
    end
  endgenerate

  always_comb begin
    logic found;
    found     = 1'b0;
    winner    = '0;
    any_valid = |req;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[cand[i]]) begin
        winner = cand[i];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one enabled storage register among N_REQ requesters.
// One write slot is IDLE(capture) -> WRITE(enable/ack) -> optional GAP cycles.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MIN_GAP = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*DATA_W-1:0]   i_data,
  output logic [N_REQ-1:0]          o_ack,
  output logic                      o_reg_enable,
  output logic [DATA_W-1:0]         o_reg_data,
  output logic [$clog2(N_REQ)-1:0]  o_grant_id,
  output logic                      o_busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int GW  = gap_cnt_width(MIN_GAP);

  state_t            state_reg;
  logic [IDW-1:0]    last_grant_reg;
  logic [IDW-1:0]    grant_id_reg;
  logic [DATA_W-1:0] data_reg;
  logic [GW-1:0]     gap_cnt_reg;

  logic              any_valid;
  logic [IDW-1:0]    winner;
  logic [DATA_W-1:0] req_data [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_data
      assign req_data[gi] = i_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_grant_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req        (i_req),
    .last_grant (last_grant_reg),
    .any_valid  (any_valid),
    .winner     (winner)
  );

  // Data and winner are frozen at capture so late input changes cannot alter the write.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg      <= S_IDLE;
      last_grant_reg <= IDW'(N_REQ - 1);
      grant_id_reg   <= '0;
      data_reg       <= '0;
      gap_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (any_valid) begin
            data_reg       <= req_data[winner];
            grant_id_reg   <= winner;
            last_grant_reg <= winner;
            state_reg      <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (MIN_GAP > 0) begin
            gap_cnt_reg <= GW'(MIN_GAP - 1);
            state_reg   <= S_GAP;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt_reg == '0) begin
            state_reg <= S_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GW'(1);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign o_reg_enable = (state_reg == S_WRITE);
  assign o_busy       = (state_reg != S_IDLE);
  assign o_reg_data   = data_reg;
  assign o_grant_id   = grant_id_reg;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
      assign o_ack[gi] = o_reg_enable && (grant_id_reg == IDW'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus a randomized
// run compared against a round-robin reference model.
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   ack;
  logic           en;
  logic [W-1:0]   rdata;
  logic [1:0]     gid;
  logic           busy;

  logic           g_rst_n;
  logic [N-1:0]   g_req;
  logic [N*W-1:0] g_data;
  logic [N-1:0]   g_ack;
  logic           g_en;
  logic [W-1:0]   g_rdata;
  logic [1:0]     g_gid;
  logic           g_busy;

  logic [W-1:0]   reg_q;

  int vectors     = 0;
  int miscompares = 0;

  reg_write_arbiter #(.N_REQ(N), .DATA_W(W), .MIN_GAP(0)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_data       (data),
    .o_ack        (ack),
    .o_reg_enable (en),
    .o_reg_data   (rdata),
    .o_grant_id   (gid),
    .o_busy       (busy)
  );

  reg_write_arbiter #(.N_REQ(N), .DATA_W(W), .MIN_GAP(3)) dut_gap (
    .i_clk        (clk),
    .i_rst_n      (g_rst_n),
    .i_req        (g_req),
    .i_data       (g_data),
    .o_ack        (g_ack),
    .o_reg_enable (g_en),
    .o_reg_data   (g_rdata),
    .o_grant_id   (g_gid),
    .o_busy       (g_busy)
  );

  // Storage register fed by the arbiter.
  always @(posedge clk) begin
    if (en) reg_q <= rdata;
  end

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int i = 1; i <= N; i++) begin
      int idx;
      idx = (last + i) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    data  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    data  = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if ({ack, en, rdata, gid, busy} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: ack=%b en=%b data=%h gid=%0d busy=%b, required all 0",
                 ack, en, rdata, gid, busy);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (en !== 1'b1 || gid !== 2'd0 || ack !== 4'b0001 || rdata !== 8'h11) begin
      miscompares++;
      $display("FAIL reset_first_grant: en=%b gid=%0d ack=%b data=%h, required 1/0/0001/11",
               en, gid, ack, rdata);
    end
    $display("reset: first grant gid=%0d data=%h", gid, rdata);
    req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    data[23:16] = 8'hA5;
    @(posedge clk); #1;
    vectors++;
    if (en !== 1'b1 || rdata !== 8'hA5 || gid !== 2'd2 || ack !== 4'b0100 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_write: en=%b data=%h gid=%0d ack=%b busy=%b, required 1/a5/2/0100/1",
               en, rdata, gid, ack, busy);
    end
    req = '0;
    @(posedge clk); #1;
    vectors++;
    if (en !== 1'b0 || ack !== 4'b0000 || reg_q !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_after: en=%b ack=%b reg=%h, required 0/0000/a5", en, ack, reg_q);
    end
    $display("single: reg=%h", reg_q);
  endtask

  task automatic test_contention();
    do_reset();
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    req  = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      logic [1:0] eg;
      logic [N-1:0] ea;
      @(posedge clk); #1;
      vectors++;
      eg = 2'((i / 2) % N);
      ea = '0;
      ea[eg] = 1'b1;
      if (i % 2 == 0) begin
        if (en !== 1'b1 || gid !== eg || rdata !== (8'h10 + 8'(eg)) || ack !== ea) begin
          miscompares++;
          $display("FAIL contention_write%0d: en=%b gid=%0d data=%h ack=%b, required 1/%0d/%h/%b",
                   i / 2, en, gid, rdata, ack, eg, 8'h10 + 8'(eg), ea);
        end
        $display("contention: write %0d gid=%0d data=%h", i / 2, gid, rdata);
      end else if (en !== 1'b0 || ack !== 4'b0000) begin
        miscompares++;
        $display("FAIL contention_idle%0d: en=%b ack=%b, required 0/0000", i, en, ack);
      end
    end
    req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_late_change();
    int acks;
    do_reset();
    req = 4'b0010;
    data[15:8] = 8'h33;
    @(posedge clk); #1;
    vectors++;
    if (en !== 1'b1 || rdata !== 8'h33 || ack !== 4'b0010) begin
      miscompares++;
      $display("FAIL late_write: en=%b data=%h ack=%b, required 1/33/0010", en, rdata, ack);
    end
    data[15:8] = 8'hCC;
    req = '0;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack != '0) acks++;
    end
    vectors++;
    if (acks != 0 || reg_q !== 8'h33) begin
      miscompares++;
      $display("FAIL late_commit: extra_acks=%0d reg=%h, required 0/33", acks, reg_q);
    end
    $display("late_change: reg=%h extra_acks=%0d", reg_q, acks);
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    req = 4'b0100;
    data[23:16] = 8'h5A;
    @(posedge clk); #1;
    vectors++;
    if (en !== 1'b1 || gid !== 2'd2) begin
      miscompares++;
      $display("FAIL midrst_write: en=%b gid=%0d, required 1/2", en, gid);
    end
    rst_n = 1'b0;
    req   = 4'b1111;
    @(posedge clk); #1;
    vectors++;
    if (en !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || reg_q !== 8'h5A) begin
      miscompares++;
      $display("FAIL midrst_after: en=%b ack=%b busy=%b reg=%h, required 0/0000/0/5a",
               en, ack, busy, reg_q);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (en !== 1'b1 || gid !== 2'd0) begin
      miscompares++;
      $display("FAIL midrst_priority: en=%b gid=%0d, required 1/0", en, gid);
    end
    $display("reset_mid_write: next gid=%0d", gid);
    req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_min_gap();
    int prev;
    int pulses;
    g_req  = 4'b0011;
    g_data = {8'h43, 8'h42, 8'h41, 8'h40};
    repeat (2) @(posedge clk);
    #1 g_rst_n = 1'b1;
    prev   = -1;
    pulses = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (g_en) begin
        logic [1:0] eg;
        logic [N-1:0] ea;
        eg = 2'(pulses % 2);
        ea = '0;
        ea[eg] = 1'b1;
        vectors++;
        if ((prev >= 0 && cyc - prev != 5) || g_gid !== eg || g_ack !== ea ||
            g_rdata !== (8'h40 + 8'(eg))) begin
          miscompares++;
          $display("FAIL gap_pulse%0d: spacing=%0d gid=%0d ack=%b data=%h, required 5/%0d/%b/%h",
                   pulses, cyc - prev, g_gid, g_ack, g_rdata, eg, ea, 8'h40 + 8'(eg));
        end
        $display("min_gap: pulse %0d at cycle %0d gid=%0d", pulses, cyc, g_gid);
        prev = cyc;
        pulses++;
      end else if (prev >= 0) begin
        vectors++;
        if (g_busy !== ((cyc - prev) <= 3)) begin
          miscompares++;
          $display("FAIL gap_busy: cycle+%0d busy=%b, required %b", cyc - prev, g_busy,
                   ((cyc - prev) <= 3));
        end
      end
    end
    vectors++;
    if (pulses != 6) begin
      miscompares++;
      $display("FAIL gap_count: pulses=%0d, required 6", pulses);
    end
    g_req = '0;
  endtask

  task automatic test_random();
    int           last;
    logic         exp_en;
    int           exp_gid;
    logic [W-1:0] exp_data;
    logic [N-1:0] exp_ack;
    logic [N-1:0] pending;
    int           writes;
    do_reset();
    last     = N - 1;
    exp_en   = 1'b0;
    exp_gid  = 0;
    exp_data = '0;
    pending  = '0;
    writes   = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // A slot opens whenever the previous cycle was not a write.
      if (!exp_en && req != '0) begin
        exp_gid  = rr_pick(req, last);
        last     = exp_gid;
        exp_data = data[exp_gid*W +: W];
        exp_en   = 1'b1;
      end else begin
        exp_en = 1'b0;
      end
      exp_ack = '0;
      if (exp_en) exp_ack[exp_gid] = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (en !== exp_en || ack !== exp_ack || busy !== exp_en ||
          (exp_en && (gid !== 2'(exp_gid) || rdata !== exp_data))) begin
        miscompares++;
        $display("FAIL random_c%0d: en=%b ack=%b gid=%0d data=%h busy=%b, required %b/%b/%0d/%h/%b",
                 cyc, en, ack, gid, rdata, busy, exp_en, exp_ack, exp_gid, exp_data, exp_en);
      end
      if (exp_en) writes++;
      for (int k = 0; k < N; k++) begin
        if (exp_en && exp_gid == k) begin
          pending[k] = 1'b0;
        end else if (!pending[k] && $urandom_range(0, 2) == 0) begin
          pending[k] = 1'b1;
          data[k*W +: W] = 8'($urandom);
        end
      end
      req = pending;
    end
    $display("random: %0d writes checked over 400 cycles", writes);
    req = '0;
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    data    = '0;
    g_rst_n = 1'b0;
    g_req   = '0;
    g_data  = '0;
    test_reset();
    test_single();
    test_contention();
    test_late_change();
    test_reset_mid_write();
    test_min_gap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
